refresh_scan_gen: RTL and testbench

//  Source side of the 2-bit digit-select ("refrescamiento") bus for the 7-seg display path.

---
 rtl/refresh_scan_gen.sv | 120 ++++++++++++
 tb/tb_refresh_scan_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_scan_gen.sv
// Digit-scan timing source for the 7-segment display: steps a digit index once per slot,
// blanks the anodes at the start of each slot, and pulses per-digit and per-frame strobes.
module refresh_scan_gen #(
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int NUM_DIGITS   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [1:0] refrescamiento,
    output logic       blank,
    output logic       digit_tick,
    output logic       frame_tick
);

    localparam int             CW         = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CW-1:0]  SLOT_LAST  = CW'(DIV_COUNT - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [1:0]     IDX_LAST   = 2'(NUM_DIGITS - 1);
    localparam bit             HAS_BLANK  = (BLANK_CYCLES > 0);

    if (DIV_COUNT < 2) begin : g_badDivCount
        $error("refresh_scan_gen: DIV_COUNT must be >= 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES > DIV_COUNT - 1) begin : g_badBlankCycles
        $error("refresh_scan_gen: BLANK_CYCLES must be in 0..DIV_COUNT-1");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_badNumDigits
        $error("refresh_scan_gen: NUM_DIGITS must be in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nextCnt;
    logic [1:0]    w_nextIdx;
    logic          w_nextBlank;
    logic          w_nextDigitTick;
    logic          w_nextFrameTick;

    // Next-state logic; every output is a register loaded from these next values.
    always_comb begin
        w_nextState     = r_state;
        w_nextCnt       = r_cnt;
        w_nextIdx       = refrescamiento;
        w_nextDigitTick = 1'b0;
        w_nextFrameTick = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextCnt = '0;
                w_nextIdx = 2'd0;
                if (enable) begin
                    w_nextState = HAS_BLANK ? BLANK : SHOW;
                end
            end
            BLANK: begin
                if (!enable) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                    w_nextIdx   = 2'd0;
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                    if (r_cnt == BLANK_LAST) begin
                        w_nextState = SHOW;
                    end
                end
            end
            SHOW: begin
                if (!enable) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                    w_nextIdx   = 2'd0;
                end else if (r_cnt == SLOT_LAST) begin
                    w_nextState     = HAS_BLANK ? BLANK : SHOW;
                    w_nextCnt       = '0;
                    w_nextIdx       = (refrescamiento == IDX_LAST) ? 2'd0 : refrescamiento + 2'd1;
                    w_nextDigitTick = 1'b1;
                    w_nextFrameTick = (refrescamiento == IDX_LAST);
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
                w_nextIdx   = 2'd0;
            end
        endcase

        // Anodes stay off everywhere except the display phase of a slot.
        w_nextBlank = (w_nextState != SHOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            refrescamiento <= 2'd0;
            blank          <= 1'b1;
            digit_tick     <= 1'b0;
            frame_tick     <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_cnt          <= w_nextCnt;
            refrescamiento <= w_nextIdx;
            blank          <= w_nextBlank;
            digit_tick     <= w_nextDigitTick;
            frame_tick     <= w_nextFrameTick;
        end
    end

endmodule

// File: tb/tb_refresh_scan_gen.sv
// Self-checking bench for refresh_scan_gen: four parameterisations driven in lockstep and
// compared every cycle against an arithmetic model (elapsed cycles -> slot, digit, phase).
module tb_refresh_scan_gen;

    localparam int NCFG = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] oIdx   [NCFG];
    logic       oBlank [NCFG];
    logic       oDt    [NCFG];
    logic       oFt    [NCFG];

    int cfgDiv   [NCFG] = '{8, 8, 8, 5};
    int cfgBlank [NCFG] = '{2, 2, 0, 4};
    int cfgNum   [NCFG] = '{4, 3, 4, 1};

    bit mRun [NCFG];
    int mK   [NCFG];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    refresh_scan_gen #(.DIV_COUNT(8), .BLANK_CYCLES(2), .NUM_DIGITS(4)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .refrescamiento(oIdx[0]),
        .blank(oBlank[0]), .digit_tick(oDt[0]), .frame_tick(oFt[0]));
    refresh_scan_gen #(.DIV_COUNT(8), .BLANK_CYCLES(2), .NUM_DIGITS(3)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .refrescamiento(oIdx[1]),
        .blank(oBlank[1]), .digit_tick(oDt[1]), .frame_tick(oFt[1]));
    refresh_scan_gen #(.DIV_COUNT(8), .BLANK_CYCLES(0), .NUM_DIGITS(4)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .refrescamiento(oIdx[2]),
        .blank(oBlank[2]), .digit_tick(oDt[2]), .frame_tick(oFt[2]));
    refresh_scan_gen #(.DIV_COUNT(5), .BLANK_CYCLES(4), .NUM_DIGITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .refrescamiento(oIdx[3]),
        .blank(oBlank[3]), .digit_tick(oDt[3]), .frame_tick(oFt[3]));

    // Model: mK counts cycles since the scan started; slot, digit and phase follow by division.
    function automatic logic [1:0] expIdx(int j);
        if (!mRun[j]) return 2'd0;
        return 2'((mK[j] / cfgDiv[j]) % cfgNum[j]);
    endfunction

    function automatic logic expBlank(int j);
        if (!mRun[j]) return 1'b1;
        return ((mK[j] % cfgDiv[j]) < cfgBlank[j]);
    endfunction

    function automatic logic expDt(int j);
        if (!mRun[j]) return 1'b0;
        return ((mK[j] % cfgDiv[j]) == 0) && (mK[j] != 0);
    endfunction

    function automatic logic expFt(int j);
        return expDt(j) && (expIdx(j) == 2'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int j = 0; j < NCFG; j++) begin
            if (reset || !enable) begin
                mRun[j] = 1'b0;
                mK[j]   = 0;
            end else if (!mRun[j]) begin
                mRun[j] = 1'b1;
                mK[j]   = 0;
            end else begin
                mK[j] = mK[j] + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (oIdx[0] !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", oIdx[0]); end
            checks++; if (oBlank[0] !== 1'b1) begin errors++; $display("[TB] FAIL reset_blank got %b want 1", oBlank[0]); end
            checks++; if (oDt[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_digit_tick got %b want 0", oDt[0]); end
            checks++; if (oFt[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_tick got %b want 0", oFt[0]); end
        end
    endtask

    task automatic test_scan();
        int dtCount = 0;
        int ftCount = 0;
        reset  = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 41; c++) begin
            tick();
            dtCount += oDt[0];
            ftCount += oFt[0];
            checks++; if (oIdx[0] !== expIdx(0) || oBlank[0] !== expBlank(0) || oDt[0] !== expDt(0) || oFt[0] !== expFt(0)) begin
                errors++;
                $display("[TB] FAIL scan_c%0d got idx=%0d blank=%b dt=%b ft=%b want idx=%0d blank=%b dt=%b ft=%b",
                         c, oIdx[0], oBlank[0], oDt[0], oFt[0], expIdx(0), expBlank(0), expDt(0), expFt(0));
            end
        end
        checks++; if (dtCount !== 5) begin errors++; $display("[TB] FAIL scan_digit_ticks got %0d want 5", dtCount); end
        checks++; if (ftCount !== 1) begin errors++; $display("[TB] FAIL scan_frame_ticks got %0d want 1", ftCount); end
    endtask

    task automatic test_num3();
        int ftCount = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 49; c++) begin
            tick();
            ftCount += oFt[1];
            checks++; if (oIdx[1] !== expIdx(1) || oBlank[1] !== expBlank(1) || oDt[1] !== expDt(1) || oFt[1] !== expFt(1)) begin
                errors++;
                $display("[TB] FAIL num3_c%0d got idx=%0d blank=%b dt=%b ft=%b want idx=%0d blank=%b dt=%b ft=%b",
                         c, oIdx[1], oBlank[1], oDt[1], oFt[1], expIdx(1), expBlank(1), expDt(1), expFt(1));
            end
        end
        checks++; if (ftCount !== 2) begin errors++; $display("[TB] FAIL num3_frame_ticks got %0d want 2", ftCount); end
    endtask

    task automatic test_blank0();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 33; c++) begin
            tick();
            checks++; if (oIdx[2] !== expIdx(2) || oBlank[2] !== expBlank(2) || oDt[2] !== expDt(2) || oFt[2] !== expFt(2)) begin
                errors++;
                $display("[TB] FAIL blank0_c%0d got idx=%0d blank=%b dt=%b ft=%b want idx=%0d blank=%b dt=%b ft=%b",
                         c, oIdx[2], oBlank[2], oDt[2], oFt[2], expIdx(2), expBlank(2), expDt(2), expFt(2));
            end
        end
    endtask

    task automatic test_single_digit();
        int ftCount = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 21; c++) begin
            tick();
            ftCount += oFt[3];
            checks++; if (oIdx[3] !== expIdx(3) || oBlank[3] !== expBlank(3) || oDt[3] !== expDt(3) || oFt[3] !== expFt(3)) begin
                errors++;
                $display("[TB] FAIL single_c%0d got idx=%0d blank=%b dt=%b ft=%b want idx=%0d blank=%b dt=%b ft=%b",
                         c, oIdx[3], oBlank[3], oDt[3], oFt[3], expIdx(3), expBlank(3), expDt(3), expFt(3));
            end
        end
        checks++; if (ftCount !== 4) begin errors++; $display("[TB] FAIL single_frame_ticks got %0d want 4", ftCount); end
    endtask

    task automatic test_enable_drop();
        int guard = 0;
        reset = 1'b1; enable = 1'b1; tick(); reset = 1'b0;
        tick();
        while (mK[0] != 23 && guard < 40) begin tick(); guard++; end
        checks++; if (oIdx[0] !== 2'd2 || oBlank[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_pre got idx=%0d blank=%b want idx=2 blank=0", oIdx[0], oBlank[0]);
        end
        enable = 1'b0;
        tick();
        checks++; if (oIdx[0] !== 2'd0 || oBlank[0] !== 1'b1 || oDt[0] !== 1'b0 || oFt[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL drop_idle got idx=%0d blank=%b dt=%b ft=%b want 0 1 0 0", oIdx[0], oBlank[0], oDt[0], oFt[0]);
        end
        enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (oIdx[0] !== 2'd0 || oBlank[0] !== (c < 2) || oDt[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL drop_restart_c%0d got idx=%0d blank=%b dt=%b want idx=0 blank=%b dt=0",
                                   c, oIdx[0], oBlank[0], oDt[0], (c < 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (mK[0] != 12 && guard < 40) begin tick(); guard++; end
        checks++; if (oIdx[0] !== 2'd1 || oBlank[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_pre got idx=%0d blank=%b want idx=1 blank=0", oIdx[0], oBlank[0]);
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (oIdx[0] !== 2'd0 || oBlank[0] !== 1'b1 || oDt[0] !== 1'b0 || oFt[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL midreset_held_c%0d got idx=%0d blank=%b dt=%b ft=%b want 0 1 0 0",
                                   c, oIdx[0], oBlank[0], oDt[0], oFt[0]);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (oIdx[0] !== expIdx(0) || oBlank[0] !== expBlank(0) || oDt[0] !== expDt(0) || oFt[0] !== expFt(0)) begin
                errors++;
                $display("[TB] FAIL midreset_after_c%0d got idx=%0d blank=%b dt=%b ft=%b want idx=%0d blank=%b dt=%b ft=%b",
                         c, oIdx[0], oBlank[0], oDt[0], oFt[0], expIdx(0), expBlank(0), expDt(0), expFt(0));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            enable = ($urandom_range(0, 29) != 0);
            reset  = ($urandom_range(0, 149) == 0);
            tick();
            for (int j = 0; j < NCFG; j++) begin
                checks++; if (oIdx[j] !== expIdx(j) || oBlank[j] !== expBlank(j) || oDt[j] !== expDt(j) || oFt[j] !== expFt(j)) begin
                    errors++;
                    $display("[TB] FAIL random_c%0d_cfg%0d got idx=%0d blank=%b dt=%b ft=%b want idx=%0d blank=%b dt=%b ft=%b",
                             c, j, oIdx[j], oBlank[j], oDt[j], oFt[j], expIdx(j), expBlank(j), expDt(j), expFt(j));
                end
            end
        end
    endtask

    initial begin
        for (int j = 0; j < NCFG; j++) begin
            mRun[j] = 1'b0;
            mK[j]   = 0;
        end
        #2;
        test_reset();
        test_scan();
        test_num3();
        test_blank0();
        test_single_digit();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
